uart_rx_key_decoder: RTL and testbench

//  Receive end of the key-report serial link: 8N1 UART receiver, LSB first, idle-high line.

---
 rtl/uart_rx_key_decoder.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_key_decoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_key_decoder.sv
// -----------------------------------------------------------------------------
// uart_rx_key_decoder
//   Receive end of the key-report serial link. This is an 8N1 UART receiver:
//   LSB first, idle-high line. It recovers each byte and flags framing errors.
//   It can also decode ASCII hex digits back into a 4-bit key code.
//
//   Optional feature macro: RX_KEY_DECODE_EN
//     defined   : '0'..'9', 'A'..'F' and 'a'..'f' map to key_code_o 0..15.
//                 key_code_o and key_valid_o update in the same cycle as
//                 data_valid_o.
//     undefined : no decoder is built. key_code_o = 4'h0, key_valid_o = 1'b0.
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        line rate in bit/s
//               CLK_FREQ/BAUD must be >= 8
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   rxd_i         in   serial input, asynchronous to clk, idle high
//   data_out_o    out  [7:0] last correctly framed byte
//   data_valid_o  out  1-cycle pulse, data_out_o just updated
//   frame_err_o   out  1-cycle pulse, stop bit sampled low
//   busy_o        out  high whenever the receiver is not idle
//   key_code_o    out  [3:0] decoded key nibble
//   key_valid_o   out  1-cycle pulse, key_code_o just updated
// -----------------------------------------------------------------------------
module uart_rx_key_decoder #(
    parameter int CLK_FREQ = 27_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd_i,
    output logic [7:0] data_out_o,
    output logic       data_valid_o,
    output logic       frame_err_o,
    output logic       busy_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    // Mid-bit point of the start bit, and the full bit period, as terminal counts.
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t           state_q;
    logic             rxd_meta_q;
    logic             rxs_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_out_q;
    logic             data_valid_q;
    logic             frame_err_q;
    logic             busy_q;

    // Two-flop synchroniser for the asynchronous RX pin. Both flops reset to idle-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxs_q      <= 1'b1;
        end else begin
            rxd_meta_q <= rxd_i;
            rxs_q      <= rxd_meta_q;
        end
    end

    // Receive FSM. The byte and pulse outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (!rxs_q) begin
                            state_q   <= S_DATA;
                            bit_idx_q <= 3'd0;
                        end else begin
                            // Line went back high before mid start bit: treat as a glitch.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        // Bits arrive LSB first. Each new bit enters at the MSB,
                        // so the byte is aligned after the 8th shift.
                        shift_q <= {rxs_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (rxs_q) begin
                            data_out_q   <= shift_q;
                            data_valid_q <= 1'b1;
                            state_q      <= S_IDLE;
                            busy_q       <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    // A held-low (break) line must not be re-detected as a start bit.
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out_o   = data_out_q;
    assign data_valid_o = data_valid_q;
    assign frame_err_o  = frame_err_q;
    assign busy_o       = busy_q;

`ifdef RX_KEY_DECODE_EN
    logic [3:0] key_code_q;
    logic       key_valid_q;
    logic [4:0] key_dec_s;
    logic       stop_good_s;

    // Decode an ASCII hex digit. The result is {hit, nibble}.
    // 'A'..'F' and 'a'..'f' both have low nibbles 1..6, so adding 9 gives 10..15.
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        logic [4:0] r;
        r = 5'b0_0000;
        if ((b >= 8'h30) && (b <= 8'h39)) begin
            r = {1'b1, b[3:0]};
        end else if (((b >= 8'h41) && (b <= 8'h46)) || ((b >= 8'h61) && (b <= 8'h66))) begin
            r = {1'b1, b[3:0] + 4'd9};
        end else begin
            r = 5'b0_0000;
        end
        return r;
    endfunction

    assign key_dec_s   = hex_decode(shift_q);
    // Same condition under which the FSM latches data_out, so the key and byte
    // outputs move together.
    assign stop_good_s = (state_q == S_STOP) && (cnt_q == FULL_M1) && rxs_q;

    // Key register: updated alongside data_out when the byte is a hex digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (stop_good_s && key_dec_s[4]) begin
                key_code_q  <= key_dec_s[3:0];
                key_valid_q <= 1'b1;
            end
        end
    end

    assign key_code_o  = key_code_q;
    assign key_valid_o = key_valid_q;
`else
    assign key_code_o  = 4'h0;
    assign key_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_key_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_key_decoder
//   Scoreboard bench for uart_rx_key_decoder at 27 MHz / 115200 baud
//   (234 clocks per bit). Each expected receive event is queued when its frame
//   is driven. A monitor pops the queue on every data_valid/frame_err pulse.
//   The bench builds with or without RX_KEY_DECODE_EN.
// -----------------------------------------------------------------------------
module tb_uart_rx_key_decoder;

    localparam int CLK_FREQ = 27_000_000;
    localparam int BAUD     = 115200;
    localparam int CPB      = CLK_FREQ / BAUD;
    // Clocks from the rxd falling edge to the visible data_valid pulse:
    // 2 synchroniser cycles, 1 cycle to enter START, half a bit to the start
    // sample, then 8 data bits and the stop bit.
    localparam int LATENCY  = 3 + CPB / 2 + 9 * CPB;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
    logic [3:0] key_code;
    logic       key_valid;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        logic       kv;
        logic [3:0] kc;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp;
    int         n_mis;
    int         cyc;
    int         start_cyc;
    int         pulse_cyc;
    logic       prev_pulse;
    logic [7:0] last_good;
    logic [3:0] key_model;

    uart_rx_key_decoder #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd_i       (rxd),
        .data_out_o  (data_out),
        .data_valid_o(data_valid),
        .frame_err_o (frame_err),
        .busy_o      (busy),
        .key_code_o  (key_code),
        .key_valid_o (key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference hex-digit decode, written independently of the RTL.
    task automatic model_key(input logic [7:0] b, output logic hit, output logic [3:0] nib);
        logic [7:0] t;
        hit = 1'b1;
        t   = 8'h00;
        if (b >= 8'h30 && b <= 8'h39)      t = b - 8'h30;
        else if (b >= 8'h41 && b <= 8'h46) t = b - 8'h41 + 8'd10;
        else if (b >= 8'h61 && b <= 8'h66) t = b - 8'h61 + 8'd10;
        else                               hit = 1'b0;
        nib = t[3:0];
    endtask

    task automatic push_data(input logic [7:0] b);
        exp_t       e;
        logic       hit;
        logic [3:0] nib;
        model_key(b, hit, nib);
        e.is_err  = 1'b0;
        e.data    = b;
        last_good = b;
`ifdef RX_KEY_DECODE_EN
        if (hit) key_model = nib;
        e.kv = hit;
        e.kc = key_model;
`else
        e.kv = 1'b0;
        e.kc = 4'h0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = last_good;
        e.kv     = 1'b0;
        e.kc     = key_model;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rxd       = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4 * CPB && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    // Scoreboard monitor. It samples on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (data_valid || frame_err) begin
            check("pulse_excl", {31'd0, data_valid & frame_err}, 0);
            check("pulse_gap", {31'd0, prev_pulse}, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, data_valid, frame_err}, 0);
            end else begin
                e = exp_q.pop_front();
                check("is_err", {31'd0, frame_err}, {31'd0, e.is_err});
                check("data_out", {24'd0, data_out}, {24'd0, e.data});
                check("key_valid", {31'd0, key_valid}, {31'd0, e.kv});
                check("key_code", {28'd0, key_code}, {28'd0, e.kc});
                pulse_cyc <= cyc;
            end
        end else if (key_valid) begin
            check("stray_key_valid", {31'd0, key_valid}, 0);
        end
        prev_pulse <= data_valid | frame_err;
    end

    initial begin
        n_cmp      = 0;
        n_mis      = 0;
        cyc        = 0;
        start_cyc  = 0;
        pulse_cyc  = 0;
        prev_pulse = 1'b0;
        last_good  = 8'h00;
        key_model  = 4'h0;
        rxd        = 1'b1;
        rst_n      = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_data_out", {24'd0, data_out}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_key_code", {28'd0, key_code}, 0);
        check("rst_pulses", {29'd0, data_valid, frame_err, key_valid}, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 0);

        // Test 1: a single '7'. Check busy throughout and the pulse latency.
        push_data(8'h37);
        fork
            send_byte(8'h37, 1'b1);
            begin
                repeat (10) @(negedge clk);
                check("t1_busy_start", {31'd0, busy}, 1);
                repeat (5 * CPB) @(negedge clk);
                check("t1_busy_mid", {31'd0, busy}, 1);
            end
        join
        wait_drain();
        check("t1_latency", pulse_cyc - start_cyc, LATENCY);
        check("t1_busy_end", {31'd0, busy}, 0);

        // Test 2: back-to-back 'B' then 'c', followed by a non-hex 'Z'.
        push_data(8'h42);
        push_data(8'h63);
        push_data(8'h5A);
        send_byte(8'h42, 1'b1);
        send_byte(8'h63, 1'b1);
        send_byte(8'h5A, 1'b1);
        wait_drain();

        // Test 3: framing error on 8'hA5, then a good '1'.
        push_err();
        send_byte(8'hA5, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        wait_drain();
        check("t3_busy", {31'd0, busy}, 0);
        push_data(8'h31);
        send_byte(8'h31, 1'b1);
        wait_drain();

        // Test 4: a 50-clock low glitch must be rejected silently.
        @(negedge clk);
        rxd = 1'b0;
        repeat (50) @(negedge clk);
        check("t4_busy_glitch", {31'd0, busy}, 1);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        check("t4_busy_after", {31'd0, busy}, 0);

        // Test 5: a 20-bit break gives exactly one frame error, then '0' is received.
        push_err();
        @(negedge clk);
        rxd = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        check("t5_busy_break", {31'd0, busy}, 1);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        wait_drain();
        check("t5_busy_idle", {31'd0, busy}, 0);
        push_data(8'h30);
        send_byte(8'h30, 1'b1);
        wait_drain();

        // Test 6: reset during data bit 4, then 'F' is received cleanly.
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rxd = i[0];
            repeat (CPB) @(negedge clk);
        end
        check("t6_busy_pre", {31'd0, busy}, 1);
        rst_n = 1'b0;
        rxd   = 1'b1;
        @(negedge clk);
        check("t6_rst_busy", {31'd0, busy}, 0);
        check("t6_rst_data", {24'd0, data_out}, 0);
        check("t6_rst_key", {28'd0, key_code}, 0);
        last_good = 8'h00;
        key_model = 4'h0;
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("t6_busy_rel", {31'd0, busy}, 0);
        push_data(8'h46);
        send_byte(8'h46, 1'b1);
        wait_drain();
        repeat (CPB) @(negedge clk);
`ifdef RX_KEY_DECODE_EN
        check("t6_key_final", {28'd0, key_code}, 32'hF);
`else
        check("t6_key_final", {28'd0, key_code}, 0);
`endif
        check("t6_data_final", {24'd0, data_out}, 32'h46);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
